// File: rtl/async_fifo_wr_ptr_pkg.sv
// rtl/async_fifo_wr_ptr_pkg.sv - shared constants and Gray decode for the async FIFO pointer blocks
package async_fifo_wr_ptr_pkg;

  // Default FIFO geometry; the pointer carries one extra wrap bit over the address.
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int PTR_WIDTH          = DEFAULT_ADDR_WIDTH + 1;

  // Widest pointer the shared decode function accepts; narrower pointers are zero-extended.
  localparam int MAX_PTR_WIDTH = 32;

  // Gray to binary by prefix XOR from the MSB down. Leading zeros from
  // zero-extension leave the running XOR untouched, so any width up to
  // MAX_PTR_WIDTH decodes correctly.
  function automatic logic [MAX_PTR_WIDTH-1:0] gray_to_bin(input logic [MAX_PTR_WIDTH-1:0] gray);
    logic [MAX_PTR_WIDTH-1:0] bin;
    logic                     acc;
    bin = '0;
    acc = 1'b0;
    for (int i = MAX_PTR_WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ptr_if.sv
// rtl/async_fifo_wr_ptr_if.sv - producer handshake and RAM write port of the FIFO write side
interface async_fifo_wr_ptr_if
  import async_fifo_wr_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] waddr_o;

  // Producer / RAM side that drives requests and observes the accept.
  modport master (
    output wr_valid_i,
    input  wr_ready_o,
    input  wr_en_o,
    input  waddr_o
  );

  // Pointer block side that accepts requests and drives the RAM port.
  modport slave (
    input  wr_valid_i,
    output wr_ready_o,
    output wr_en_o,
    output waddr_o
  );

endinterface

// File: rtl/bin2gray_converter.sv
// rtl/bin2gray_converter.sv - binary to reflected Gray code encoder
module bin2gray_converter #(
  parameter int DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray2bin_converter.sv
// rtl/gray2bin_converter.sv - reflected Gray code to binary decoder
module gray2bin_converter #(
  parameter int DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] bin
);

  // Prefix XOR from the MSB: each binary bit is the XOR of all Gray bits above and at it.
  always_comb begin
    logic acc;
    bin = '0;
    acc = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/async_fifo_wr_ptr.sv
// rtl/async_fifo_wr_ptr.sv - write-side pointer, Gray export and full/level flags of an async FIFO
module async_fifo_wr_ptr
  import async_fifo_wr_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  async_fifo_wr_ptr_if.slave    wr_if,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync_i,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_level_o
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_THRESH = PW'(AFULL_LEVEL);

  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] wptr_gray;
  logic          full;
  logic          afull;
  logic [PW-1:0] level;

  logic          wr_en;
  logic [PW-1:0] wptr_bin_next;
  logic [PW-1:0] wptr_gray_next;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] full_pattern;
  logic          full_next;
  logic [PW-1:0] level_next;
  logic          afull_next;

  // A request is taken only while the registered full flag is clear, so
  // there is no same-cycle path from wr_valid_i into the flags.
  assign wr_en            = wr_if.wr_valid_i & ~full;
  assign wr_if.wr_en_o    = wr_en;
  assign wr_if.wr_ready_o = ~full;
  assign wr_if.waddr_o    = wptr_bin[ADDR_WIDTH-1:0];

  // The pointer advances by the accepted write; the extra bit wraps naturally.
  always_comb begin
    wptr_bin_next = wptr_bin + PW'(wr_en);
  end

  bin2gray_converter #(
    .DATA_WIDTH (PW)
  ) u_wptr_b2g (
    .bin  (wptr_bin_next),
    .gray (wptr_gray_next)
  );

  gray2bin_converter #(
    .DATA_WIDTH (PW)
  ) u_rptr_g2b (
    .gray (rptr_gray_sync_i),
    .bin  (rptr_bin)
  );

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that means the top two bits differ and the rest match.
  // Level uses the synchronized (stale) read pointer, so it can only over-report.
  always_comb begin
    full_pattern = {~rptr_gray_sync_i[PW-1 -: 2], rptr_gray_sync_i[PW-3:0]};
    full_next    = (wptr_gray_next == full_pattern);
    level_next   = wptr_bin_next - rptr_bin;
    afull_next   = (level_next >= AFULL_THRESH);
  end

  // All state reloads every cycle; reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_bin  <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      afull     <= 1'b0;
      level     <= '0;
    end else begin
      wptr_bin  <= wptr_bin_next;
      wptr_gray <= wptr_gray_next;
      full      <= full_next;
      afull     <= afull_next;
      level     <= level_next;
    end
  end

  // The Gray pointer leaves straight from its flop so the crossing sees no glitches.
  assign wptr_gray_o   = wptr_gray;
  assign full_o        = full;
  assign almost_full_o = afull;
  assign wr_level_o    = level;

endmodule

// File: tb/tb_async_fifo_wr_ptr.sv
// tb/tb_async_fifo_wr_ptr.sv - randomized model-checked bench for the FIFO write-side pointer
module tb_async_fifo_wr_ptr;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AFULL = DEPTH - 1;

  logic        clk;
  logic        rst_n;
  logic [AW:0] rptr_gray_sync_i;
  logic [AW:0] wptr_gray_o;
  logic        full_o;
  logic        almost_full_o;
  logic [AW:0] wr_level_o;

  async_fifo_wr_ptr_if #(.ADDR_WIDTH(AW)) wr_if ();

  async_fifo_wr_ptr #(
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_if            (wr_if),
    .rptr_gray_sync_i (rptr_gray_sync_i),
    .wptr_gray_o      (wptr_gray_o),
    .full_o           (full_o),
    .almost_full_o    (almost_full_o),
    .wr_level_o       (wr_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // r_bin is the read count the bench presents (as Gray) to the block.
  int r_bin = 0;
  assign rptr_gray_sync_i = (AW+1)'((r_bin % (2*DEPTH)) ^ ((r_bin % (2*DEPTH)) >> 1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: total accepted writes and the read count seen at each edge.
  int m_w = 0;
  int m_r_seen = 0;
  int exp_level;
  bit m_full;
  assign exp_level = m_w - m_r_seen;
  assign m_full    = (exp_level == DEPTH);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_w      <= 0;
      m_r_seen <= 0;
    end else begin
      if (wr_if.wr_valid_i && !m_full) m_w <= m_w + 1;
      m_r_seen <= r_bin;
    end
  end

  function automatic int gray_of(input int w);
    int b;
    b = w % (2*DEPTH);
    return b ^ (b >> 1);
  endfunction

  // Every running cycle the DUT must match the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("level",    int'(wr_level_o),       exp_level);
      chk("full",     int'(full_o),           int'(m_full));
      chk("afull",    int'(almost_full_o),    int'(exp_level >= AFULL));
      chk("waddr",    int'(wr_if.waddr_o),    m_w % DEPTH);
      chk("gray",     int'(wptr_gray_o),      gray_of(m_w));
      chk("ready",    int'(wr_if.wr_ready_o), int'(!m_full));
      chk("wr_en",    int'(wr_if.wr_en_o),    int'(wr_if.wr_valid_i && !m_full));
    end
  end

  task automatic chk_all_reset(input string tag);
    chk({tag, "_full"},  int'(full_o), 0);
    chk({tag, "_afull"}, int'(almost_full_o), 0);
    chk({tag, "_level"}, int'(wr_level_o), 0);
    chk({tag, "_gray"},  int'(wptr_gray_o), 0);
    chk({tag, "_waddr"}, int'(wr_if.waddr_o), 0);
    chk({tag, "_ready"}, int'(wr_if.wr_ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gseq [16];
    int rd_pct;
    int k;

    rst_n = 1'b1;
    wr_if.wr_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_reset("rst_async");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle after release
    repeat (3) @(negedge clk);
    chk("idle_level", int'(wr_level_o), 0);
    chk("idle_gray",  int'(wptr_gray_o), 0);

    // Fill with 16 back-to-back writes
    #1 wr_if.wr_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      gseq[i] = int'(wptr_gray_o);
      if (i == 13) chk("afull_after14", int'(almost_full_o), 0);
      if (i == 14) chk("afull_after15", int'(almost_full_o), 1);
      if (i == 14) chk("notfull_after15", int'(full_o), 0);
    end
    chk("gseq1", gseq[0], 1);
    chk("gseq2", gseq[1], 3);
    chk("gseq3", gseq[2], 2);
    chk("gseq4", gseq[3], 6);
    chk("fill_gray",  int'(wptr_gray_o), 'h18);
    chk("fill_full",  int'(full_o), 1);
    chk("fill_level", int'(wr_level_o), 16);
    chk("fill_ready", int'(wr_if.wr_ready_o), 0);

    // Write while full
    repeat (5) begin
      @(negedge clk);
      chk("wwf_en",    int'(wr_if.wr_en_o), 0);
      chk("wwf_gray",  int'(wptr_gray_o), 'h18);
      chk("wwf_level", int'(wr_level_o), 16);
    end
    #1 wr_if.wr_valid_i = 1'b0;

    // Drain two entries via read-pointer Gray steps 0->1->3
    @(negedge clk); #1 r_bin = 1;
    @(negedge clk); #1 r_bin = 2;
    @(negedge clk);
    chk("drain_full",  int'(full_o), 0);
    chk("drain_level", int'(wr_level_o), 14);

    // Randomized writes and read advances, wrapping the pointer many times
    for (int c = 0; c < 400; c++) begin
      case (c / 100)
        0: rd_pct = 30;
        1: rd_pct = 70;
        2: rd_pct = 90;
        default: rd_pct = 20;
      endcase
      #1;
      wr_if.wr_valid_i = ($urandom_range(0, 3) != 0);
      if (r_bin < m_w && $urandom_range(0, 99) < rd_pct) r_bin = r_bin + 1;
      @(negedge clk);
    end
    chk("wrap_happened", int'(m_w > 2*DEPTH + 8), 1);

    // Level 15 with a simultaneous write and read advance stays at 15
    #1 wr_if.wr_valid_i = 1'b1;
    k = 0;
    while (!full_o && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("refill_full", int'(full_o), 1);
    #1 wr_if.wr_valid_i = 1'b0;
    r_bin = r_bin + 1;
    @(negedge clk);
    chk("l15_level", int'(wr_level_o), 15);
    #1 wr_if.wr_valid_i = 1'b1;
    r_bin = r_bin + 1;
    @(negedge clk);
    chk("simul_level", int'(wr_level_o), 15);
    chk("simul_full",  int'(full_o), 0);
    #1 wr_if.wr_valid_i = 1'b0;

    // Clean reset, 7 writes, then mid-cycle reset pulse
    rst_n = 1'b0;
    r_bin = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    wr_if.wr_valid_i = 1'b1;
    repeat (7) @(negedge clk);
    #1 wr_if.wr_valid_i = 1'b0;
    chk("seven_waddr", int'(wr_if.waddr_o), 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_reset("rst_mid");
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1 wr_if.wr_valid_i = 1'b1;
    @(negedge clk);
    chk("post_rst_waddr", int'(wr_if.waddr_o), 1);
    chk("post_rst_gray",  int'(wptr_gray_o), 1);
    #1 wr_if.wr_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
